// File: rtl/pipereg_hs.sv
// Valid/ready pipeline register with stall, flush and drop accounting.
// Define PIPEREG_SKID_EN for a two-entry skid buffer; the default build holds a single entry.
module pipereg_hs #(
   parameter int               WIDTH  = 64,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             stall,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] drop_cnt
);

   // State encoding equals the number of held entries.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] skid_r;
   logic [CNT_W-1:0] drop_cnt_r;

   logic in_ready_s;
   logic out_valid_s;
   logic in_fire_s;
   logic out_fire_s;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      if (sum[CNT_W]) begin
         return {CNT_W{1'b1}};
      end else begin
         return sum[CNT_W-1:0];
      end
   endfunction

   // Handshake qualifiers: the skid build decides in_ready from registered state only.
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
`ifdef PIPEREG_SKID_EN
      in_ready_s  = (state_r != S_TWO) & ~stall;
`else
      in_ready_s  = ~stall & ((state_r == S_EMPTY) | out_ready);
`endif
      out_valid_s = (state_r != S_EMPTY) & ~stall;
      in_fire_s   = in_valid & in_ready_s;
      out_fire_s  = out_valid_s & out_ready;
   end

   // Occupancy FSM with head/skid payload and drop counter; flush outranks stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_EMPTY;
         head_r     <= BUBBLE;
         skid_r     <= BUBBLE;
         drop_cnt_r <= {CNT_W{1'b0}};
      end else if (flush) begin
         state_r    <= S_EMPTY;
         head_r     <= BUBBLE;
         skid_r     <= BUBBLE;
         drop_cnt_r <= sat_add(drop_cnt_r, state_r);
      end else if (stall) begin
         state_r    <= state_r;
         head_r     <= head_r;
         skid_r     <= skid_r;
         drop_cnt_r <= drop_cnt_r;
      end else begin
         case (state_r)
            S_EMPTY: begin
               if (in_fire_s) begin
                  head_r  <= in_data;
                  state_r <= S_ONE;
               end else begin
                  state_r <= S_EMPTY;
               end
            end
            S_ONE: begin
               case ({in_fire_s, out_fire_s})
                  2'b11: begin
                     head_r  <= in_data;
                     state_r <= S_ONE;
                  end
                  2'b01: begin
                     head_r  <= BUBBLE;
                     state_r <= S_EMPTY;
                  end
                  2'b10: begin
                     skid_r  <= in_data;
                     state_r <= S_TWO;
                  end
                  default: begin
                     state_r <= S_ONE;
                  end
               endcase
            end
            S_TWO: begin
               // Full skid: in_ready is low here, so only a drain can happen.
               if (out_fire_s) begin
                  head_r  <= skid_r;
                  skid_r  <= BUBBLE;
                  state_r <= S_ONE;
               end else begin
                  state_r <= S_TWO;
               end
            end
            default: begin
               state_r <= S_EMPTY;
               head_r  <= BUBBLE;
               skid_r  <= BUBBLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign out_data  = head_r;
   assign occupancy = state_r;
   assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pipereg_hs.sv
// Scoreboard bench for pipereg_hs: directed stimulus pushes expected payloads, a monitor checks deliveries.
// Builds for either PIPEREG_SKID_EN setting.
module tb_pipereg_hs;
   localparam int               WIDTH  = 16;
   localparam logic [WIDTH-1:0] BUBBLE = 16'hDEAD;
   localparam int               CNT_W  = 2;

   logic             clk = 1'b0;
   logic             reset, flush, stall, in_valid, out_ready;
   logic             in_ready, out_valid;
   logic [WIDTH-1:0] in_data, out_data;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] drop_cnt;

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] exp_q[$];

`ifdef PIPEREG_SKID_EN
   localparam int MAX_OCC = 2;
`else
   localparam int MAX_OCC = 1;
`endif

   pipereg_hs #(.WIDTH(WIDTH), .BUBBLE(BUBBLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      next();
      next();
      reset = 1'b0;
   endtask

   // Monitor: a transfer that will complete at the next edge is compared with the queue head.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {16'h0, out_data}, 32'hFFFF_FFFF);
         end else begin
            chk("out_data_order", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [CNT_W-1:0] sat_exp[4];
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3;

      // Reset held while an entry is offered.
      reset = 1'b1; flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'h1234;
      next();
      sample();
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_data", {16'h0, out_data}, {16'h0, BUBBLE});
      chk("rst_drop_cnt", {30'h0, drop_cnt}, 32'h0);
      chk("rst_occupancy", {30'h0, occupancy}, 32'h0);
      next();
      reset = 1'b0; in_valid = 1'b0;
      sample();
      chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
      next();

      // Stream 1,2,3 with downstream always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = (i < 3);
         in_data  = 16'(i + 1);
         if (i < 3) exp_q.push_back(16'(i + 1));
         sample();
         chk("stream_in_ready", {31'h0, in_ready}, 32'h1);
         if (i > 0) begin
            chk("stream_head", {16'h0, out_data}, i);
            chk("stream_occ", {30'h0, occupancy}, 32'h1);
         end
         next();
      end
      in_valid = 1'b0;
      sample();
      chk("stream_drained_occ", {30'h0, occupancy}, 32'h0);
      chk("stream_drained_bubble", {16'h0, out_data}, {16'h0, BUBBLE});
      chk("stream_queue_empty", exp_q.size(), 32'h0);
      next();

      // Backpressure: push A then B while downstream is blocked.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h000A; exp_q.push_back(16'h000A);
      next();
      in_data = 16'h000B;
`ifdef PIPEREG_SKID_EN
      exp_q.push_back(16'h000B);
      sample();
      chk("bp_second_ready", {31'h0, in_ready}, 32'h1);
      next();
      in_valid = 1'b0;
      sample();
      chk("bp_occ_full", {30'h0, occupancy}, 32'h2);
      chk("bp_full_not_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_head_a", {16'h0, out_data}, 32'hA);
      next();
`else
      sample();
      chk("bp_single_not_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_single_occ", {30'h0, occupancy}, 32'h1);
      next();
      in_valid = 1'b0;
`endif
      out_ready = 1'b1;
      repeat (MAX_OCC) next();
      sample();
      chk("bp_drained_occ", {30'h0, occupancy}, 32'h0);
      chk("bp_queue_empty", exp_q.size(), 32'h0);
      next();

      // Stall for three cycles with head 0x55 and a competing offer.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055; exp_q.push_back(16'h0055);
      next();
      stall = 1'b1; out_ready = 1'b1; in_data = 16'h0066;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("stall_out_valid", {31'h0, out_valid}, 32'h0);
         chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
         chk("stall_occ", {30'h0, occupancy}, 32'h1);
         chk("stall_head", {16'h0, out_data}, 32'h55);
         next();
      end
      stall = 1'b0; in_valid = 1'b0;
      sample();
      chk("unstall_out_valid", {31'h0, out_valid}, 32'h1);
      next();
      sample();
      chk("unstall_drained_occ", {30'h0, occupancy}, 32'h0);
      chk("stall_queue_empty", exp_q.size(), 32'h0);
      next();

      // Flush under stall with the buffer full; the concurrent offer is dropped.
      do_reset();
      in_valid = 1'b1; in_data = 16'h0011;
      next();
      in_data = 16'h0022;
      next();
      stall = 1'b1; flush = 1'b1; in_data = 16'h0099;
      sample();
      chk("flush_pre_occ", {30'h0, occupancy}, MAX_OCC);
      next();
      stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      sample();
      chk("flush_occ", {30'h0, occupancy}, 32'h0);
      chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
      chk("flush_bubble", {16'h0, out_data}, {16'h0, BUBBLE});
      chk("flush_drop_cnt", {30'h0, drop_cnt}, MAX_OCC);
      next();

      // Four single-entry flushes saturate a 2-bit counter.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 16'(16'h0100 + i);
         next();
         in_valid = 1'b0; flush = 1'b1;
         next();
         flush = 1'b0;
         sample();
         chk("sat_drop_cnt", {30'h0, drop_cnt}, {30'h0, sat_exp[i]});
         next();
      end

      // Asynchronous reset mid-cycle while an entry is held.
      in_valid = 1'b1; in_data = 16'h0077;
      next();
      in_valid = 1'b0;
      sample();
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_occ", {30'h0, occupancy}, 32'h0);
      chk("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("async_rst_bubble", {16'h0, out_data}, {16'h0, BUBBLE});
      chk("async_rst_drop_cnt", {30'h0, drop_cnt}, 32'h0);
      next();
      reset = 1'b0;
      sample();
      chk("final_queue_empty", exp_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipereg_hs.md
PIPEREG_HS -- requirements
Module: pipereg_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 64: payload width in bits.
REQ-002 SHALL have parameter BUBBLE, default '0 (WIDTH bits): out_data value driven when the stage holds no valid entry.
REQ-003 SHALL have parameter CNT_W, default 16: width of the drop counter.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: synchronous discard of all held entries.
REQ-007 SHALL have port stall, input, 1: freezes both sides (cache-wait / multi-cycle EX hold).
REQ-008 SHALL have port in_valid, input, 1: upstream entry present.
REQ-009 SHALL have port in_ready, output, 1: stage accepts an entry this cycle.
REQ-010 SHALL have port in_data, input, WIDTH: upstream payload.
REQ-011 SHALL have port out_valid, output, 1: head entry presented downstream.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes the head.
REQ-013 SHALL have port out_data, output, WIDTH: head payload, or BUBBLE when empty.
REQ-014 SHALL have port occupancy, output, 2: entries held (0..2).
REQ-015 SHALL have port drop_cnt, output, CNT_W: count of valid entries discarded by flush.

Function
REQ-016 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-017 SHALL drive out_valid = (occupancy != 0) & ~stall; out_data SHALL stay the head payload during stall.
REQ-018 SHALL, while stall=1 and flush=0, perform no transfer, force in_ready=0, and hold all state unchanged.
REQ-019 SHALL implement states EMPTY, ONE, TWO: EMPTY->ONE on in_fire; ONE->EMPTY on out_fire without in_fire; ONE->ONE on both, with the new entry becoming head the next cycle; ONE->TWO on in_fire without out_fire; TWO->ONE on out_fire, with the skid entry promoted to head.
REQ-020 SHALL preserve FIFO order; no entry SHALL be duplicated or lost except by flush.
REQ-021 SHALL, on flush=1 at a clock edge, go to EMPTY regardless of stall, in_valid or out_ready; an entry offered that cycle SHALL be dropped.
REQ-022 SHALL, on a flush edge, add occupancy to drop_cnt, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL give one-cycle latency: an entry accepted at edge N is presented at out_data from edge N onward.

Reset
REQ-024 SHALL, while reset=1 and independent of clk, force state EMPTY, occupancy=0, out_valid=0, out_data=BUBBLE, drop_cnt=0, skid entry=BUBBLE.
REQ-025 SHALL drive in_ready=1 on the first cycle after reset deasserts, provided stall=0.
REQ-026 SHALL abandon any in-flight transfer when reset asserts mid-operation, with no partial update surviving.

Configuration
REQ-027 SHALL support macro PIPEREG_SKID_EN; when defined: two-entry skid buffer, in_ready = (occupancy != 2) & ~stall, taken from registered state only with no combinational path from out_ready, TWO reachable.
REQ-028 SHALL, when PIPEREG_SKID_EN is undefined: single entry, TWO unreachable, occupancy <= 1, in_ready = ~stall & ((occupancy == 0) | out_ready), combinational from out_ready.

Verification
REQ-029 SHALL cover: reset held with in_valid=1, in_data=0x1234 -> out_valid=0, out_data=BUBBLE, drop_cnt=0, in_ready=1 after release.
REQ-030 SHALL cover: stream 0x1,0x2,0x3 with out_ready=1 -> outputs appear in order, each one cycle after acceptance, occupancy stays at 1.
REQ-031 SHALL cover (SKID_EN): out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0; then out_ready=1 -> 0xA then 0xB delivered.
REQ-032 SHALL cover: stall=1 for 3 cycles with head 0x55 and out_ready=1 -> out_valid=0, in_ready=0, occupancy unchanged; after release 0x55 is delivered once.
REQ-033 SHALL cover: flush asserted with stall=1 and occupancy=2 -> EMPTY next cycle, drop_cnt += 2, out_data=BUBBLE.
REQ-034 SHALL cover: CNT_W=2 with four flushes of one entry each -> drop_cnt reads 1,2,3,3 (saturates).
